// File: rtl/divider_recon.sv
// Round-trip checker for the divider: rebuilds dividend = merchant*divisor + remainder
// with an iterative shift-add multiplier, and flags tuples no valid division produces.
module divider_recon #(
  parameter int N = 5,
  parameter int M = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_rdy,
  input  logic [N-1:0]     merchant,
  input  logic [M-1:0]     divisor,
  input  logic [M-1:0]     remainder,
  output logic             busy,
  output logic             res_rdy,
  output logic [N+M-1:0]   dividend,
  output logic             err
);

  localparam int W  = N + M;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc;
  logic [W-1:0]  mcand;
  logic [W-1:0]  acc_next;
  logic [N-1:0]  mplier;
  logic          err_r;

  // Handshake: a tuple is taken at a rising edge where data_rdy=1 and busy=0;
  // data_rdy while busy is dropped. res_rdy pulses one cycle with dividend/err valid.
  assign busy = (state != IDLE);

  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      err_r    <= 1'b0;
      res_rdy  <= 1'b0;
      dividend <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          res_rdy <= 1'b0;
          if (data_rdy) begin
            acc    <= {{N{1'b0}}, remainder};
            mcand  <= {{N{1'b0}}, divisor};
            mplier <= merchant;
            cnt    <= '0;
            err_r  <= (divisor == '0) || (remainder >= divisor);
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Fixed N iterations even for merchant==0, so latency never varies.
          if (cnt == LAST) begin
            dividend <= acc_next;
            err      <= err_r;
            res_rdy  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          res_rdy <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          res_rdy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
